// File: rtl/parity_updown_counter.sv
// Up/down counter whose sequence is all values, only even values or only odd values,
// with a parallel load, a wrap-or-saturate boundary policy and a one-cycle wrap pulse.
module parity_updown_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             Y,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrapped
);

    typedef enum logic [1:0] {
        MODE_ALL  = 2'b00,
        MODE_EVEN = 2'b01,
        MODE_ODD  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] TWO_EXT = {{(WIDTH-1){1'b0}}, 2'b10};

    mode_e            mode_sel;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH:0]   step_val;
    logic             aligned;

    logic [WIDTH:0]   delta;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] down_diff;
    logic             over_max;
    logic             under_min;

    logic [WIDTH-1:0] q_next;
    logic             wrapped_next;

    assign mode_sel = mode_e'(mode);

    // Bounds of the selected sequence, and whether Q already lies on it.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        min_val  = '0;
        max_val  = '1;
        step_val = ONE_EXT;
        aligned  = 1'b1;
        case (mode_sel)
            MODE_EVEN: begin
                max_val  = {{(WIDTH-1){1'b1}}, 1'b0};
                step_val = TWO_EXT;
                aligned  = ~Q[0];
            end
            MODE_ODD: begin
                min_val  = {{(WIDTH-1){1'b0}}, 1'b1};
                step_val = TWO_EXT;
                aligned  = Q[0];
            end
            default: ;
        endcase
    end

    // A misaligned value moves by one onto the sequence; otherwise a full step.
    // The extra top bit lets the up-sum see past 2^WIDTH-1 before it wraps.
    assign delta     = aligned ? step_val : ONE_EXT;
    assign q_ext     = {1'b0, Q};
    assign up_sum    = q_ext + delta;
    assign down_diff = Q - delta[WIDTH-1:0];
    assign over_max  = up_sum > {1'b0, max_val};
    assign under_min = q_ext < ({1'b0, min_val} + delta);

    always_comb begin
        q_next       = Q;
        wrapped_next = 1'b0;
        if (load) begin
            q_next = d;
        end else if (en && (mode_sel != MODE_HOLD)) begin
            if (!Y) begin
                if (over_max) begin
                    q_next       = WRAP ? min_val : max_val;
                    wrapped_next = WRAP;
                end else begin
                    q_next = up_sum[WIDTH-1:0];
                end
            end else begin
                if (under_min) begin
                    q_next       = WRAP ? max_val : min_val;
                    wrapped_next = WRAP;
                end else begin
                    q_next = down_diff;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q       <= '0;
            wrapped <= 1'b0;
        end else begin
            Q       <= q_next;
            wrapped <= wrapped_next;
        end
    end

    assign tc = (mode_sel != MODE_HOLD) && (Y ? (Q == min_val) : (Q == max_val));

endmodule

// File: tb/tb_parity_updown_counter.sv
// Directed bench for parity_updown_counter: expectations are queued when a vector is
// driven and a monitor compares them against the selected instance after each edge.
module tb_parity_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       Y;
    logic [1:0] mode;
    logic       load;
    logic [3:0] d;

    logic [3:0] q_wrap;
    logic       tc_wrap;
    logic       wr_wrap;
    logic [3:0] q_sat;
    logic       tc_sat;
    logic       wr_sat;

    typedef struct {
        bit       sel;
        logic [3:0] q;
        logic       tc;
        logic       wr;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   vid          = 0;

    parity_updown_counter #(.WIDTH(4), .WRAP(1'b1)) dut_wrap (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .Y       (Y),
        .mode    (mode),
        .load    (load),
        .d       (d),
        .Q       (q_wrap),
        .tc      (tc_wrap),
        .wrapped (wr_wrap)
    );

    parity_updown_counter #(.WIDTH(4), .WRAP(1'b0)) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .Y       (Y),
        .mode    (mode),
        .load    (load),
        .d       (d),
        .Q       (q_sat),
        .tc      (tc_sat),
        .wrapped (wr_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector at a falling edge and queue what the chosen instance must show
    // after the following rising edge (sel 0 = wrapping instance, 1 = saturating).
    task automatic vec(input bit sel, input logic e, input logic y, input logic [1:0] m,
                       input logic ld, input logic [3:0] dv,
                       input logic [3:0] eq, input logic et, input logic ew);
        exp_t x;
        en   = e;
        Y    = y;
        mode = m;
        load = ld;
        d    = dv;
        x.sel = sel;
        x.q   = eq;
        x.tc  = et;
        x.wr  = ew;
        x.id  = vid;
        sb.push_back(x);
        vid++;
        @(negedge clk);
    endtask

    // Called at a falling edge: reset asserted mid-cycle must clear outputs at once,
    // stay clear across a rising edge, and release at the next falling edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, ".async_q"},   32'(q_wrap),  32'd0);
        check({tag, ".async_wr"},  32'(wr_wrap), 32'd0);
        check({tag, ".async_qs"},  32'(q_sat),   32'd0);
        @(posedge clk);
        #1;
        check({tag, ".held_q"},    32'(q_wrap),  32'd0);
        check({tag, ".held_wr"},   32'(wr_wrap), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic [3:0] aq;
        logic       at;
        logic       aw;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                aq = e.sel ? q_sat  : q_wrap;
                at = e.sel ? tc_sat : tc_wrap;
                aw = e.sel ? wr_sat : wr_wrap;
                check($sformatf("v%0d.q", e.id),  32'(aq), 32'(e.q));
                check($sformatf("v%0d.tc", e.id), 32'(at), 32'(e.tc));
                check($sformatf("v%0d.wr", e.id), 32'(aw), 32'(e.wr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        Y     = 1'b1;
        mode  = 2'b01;
        load  = 1'b0;
        d     = 4'd0;
        #1;
        reset = 1'b0;
        #1;
        check("rst.q",       32'(q_wrap),  32'd0);
        check("rst.wr",      32'(wr_wrap), 32'd0);
        check("rst.q_sat",   32'(q_sat),   32'd0);
        check("rst.tc_even_down", 32'(tc_wrap), 32'd1);
        mode = 2'b10;
        #1;
        check("rst.tc_odd",  32'(tc_wrap), 32'd0);
        mode = 2'b00;
        Y    = 1'b0;
        #1;
        check("rst.tc_all_up", 32'(tc_wrap), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Even sequence upward with wrap 14 -> 0.
        vec(0, 1, 0, 2'b01, 0, 0,  2, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0,  4, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0,  6, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0,  8, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0, 10, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0, 12, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0, 14, 1, 0);
        vec(0, 1, 0, 2'b01, 0, 0,  0, 0, 1);
        vec(0, 1, 0, 2'b01, 0, 0,  2, 0, 0);

        // Load 6, even sequence downward with wrap 0 -> 14.
        vec(0, 0, 1, 2'b01, 1, 6,  6, 0, 0);
        vec(0, 1, 1, 2'b01, 0, 0,  4, 0, 0);
        vec(0, 1, 1, 2'b01, 0, 0,  2, 0, 0);
        vec(0, 1, 1, 2'b01, 0, 0,  0, 1, 0);
        vec(0, 1, 1, 2'b01, 0, 0, 14, 0, 1);

        // Reset while the wrap pulse is high, then counting restarts from 0.
        do_reset("r1");
        vec(0, 1, 0, 2'b01, 0, 0,  2, 0, 0);

        // Odd sequence from reset: alignment step, wrap 15 -> 1, reversal, wrap 1 -> 15.
        do_reset("r2");
        vec(0, 1, 0, 2'b10, 0, 0,  1, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0,  3, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0,  5, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0,  7, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0,  9, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0, 11, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0, 13, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0, 15, 1, 0);
        vec(0, 1, 0, 2'b10, 0, 0,  1, 0, 1);
        vec(0, 1, 0, 2'b10, 0, 0,  3, 0, 0);
        vec(0, 1, 0, 2'b10, 0, 0,  5, 0, 0);
        vec(0, 1, 1, 2'b10, 0, 0,  3, 0, 0);
        vec(0, 1, 1, 2'b10, 0, 0,  1, 1, 0);
        vec(0, 1, 1, 2'b10, 0, 0, 15, 0, 1);
        vec(0, 0, 1, 2'b10, 0, 0, 15, 0, 0);

        // Load wins over enable without alignment; hold mode; load in hold mode.
        vec(0, 1, 0, 2'b01, 1, 9,  9, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0, 10, 0, 0);
        vec(0, 1, 0, 2'b11, 0, 0, 10, 0, 0);
        vec(0, 1, 0, 2'b11, 1, 5,  5, 0, 0);

        // Parity boundaries: even mode at 15 going up, odd mode at 0 going down, all-mode wrap.
        vec(0, 0, 0, 2'b01, 1, 15, 15, 0, 0);
        vec(0, 1, 0, 2'b01, 0, 0,   0, 0, 1);
        vec(0, 0, 1, 2'b10, 1, 0,   0, 0, 0);
        vec(0, 1, 1, 2'b10, 0, 0,  15, 0, 1);
        vec(0, 0, 0, 2'b00, 1, 15, 15, 1, 0);
        vec(0, 1, 0, 2'b00, 0, 0,   0, 0, 1);

        // Saturating instance.
        vec(1, 0, 0, 2'b00, 1, 13, 13, 0, 0);
        vec(1, 1, 0, 2'b00, 0, 0,  14, 0, 0);
        vec(1, 1, 0, 2'b00, 0, 0,  15, 1, 0);
        vec(1, 1, 0, 2'b00, 0, 0,  15, 1, 0);
        vec(1, 1, 0, 2'b00, 0, 0,  15, 1, 0);
        vec(1, 0, 1, 2'b00, 1, 1,   1, 0, 0);
        vec(1, 1, 1, 2'b00, 0, 0,   0, 1, 0);
        vec(1, 1, 1, 2'b00, 0, 0,   0, 1, 0);
        vec(1, 0, 0, 2'b01, 1, 15, 15, 0, 0);
        vec(1, 1, 0, 2'b01, 0, 0,  14, 1, 0);
        vec(1, 0, 1, 2'b10, 1, 0,   0, 0, 0);
        vec(1, 1, 1, 2'b10, 0, 0,   1, 1, 0);

        en   = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        check("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
